spi_slave: RTL

//  SPI mode-0 responder (CPOL=0, CPHA=0, MSB first, 8-bit frames) clocked by cpu_clk.
//  - sck, cs_n and mosi come from an external master; all three are oversampled through synchronisers.
//  - Lets the CPU act as a peripheral on a bus driven by another SPI master.
//  - Buffers one byte to transmit and holds received bytes with valid/ack handshaking.

---
 rtl/spi_slave_if.sv | 26 ++
 rtl/spi_slave.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// Signal bundle between an SPI mode-0 responder and its surroundings:
// the external master's pins plus the CPU-side tx/rx handshake.
interface spi_slave_if;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data_bus;
    logic       tx_load;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       overrun;

    modport slave (
        input  sck, cs_n, mosi, tx_data_bus, tx_load, rx_ack,
        output miso, miso_oe, tx_empty, rx_data, rx_valid, overrun
    );

    modport master (
        output sck, cs_n, mosi, tx_data_bus, tx_load, rx_ack,
        input  miso, miso_oe, tx_empty, rx_data, rx_valid, overrun
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder (MSB first, 8-bit frames) oversampled on cpu_clk.
// Define SPI_SLAVE_RX_FIFO_EN to replace the rx holding register with a FIFO.
//
// state | meaning
// IDLE  | cs_n inactive (or not yet re-armed), miso released and low
// SHIFT | frame active, shifting on synchronised sck edges
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         FIFO_DEPTH  = 4
) (
    input logic        cpu_clk,
    input logic        rst,
    spi_slave_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("spi_slave: illegal parameter value");
    end

    logic [0:0]             state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] sync_fill;
    logic                   sck_d;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_shift;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_buf;
    logic                   tx_empty_q;
    logic                   miso_q;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall;
    logic       frame_start, byte_done, reload;
    logic [7:0] tx_next, rx_byte;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    // armed only after a genuine (post-reset) high on cs_n, so a select held low through reset starts nothing
    assign frame_start = (state == IDLE) & armed & ~cs_s;
    assign byte_done   = (state == SHIFT) & ~cs_s & sck_rise & (bit_cnt == 3'd7);
    assign reload      = frame_start | byte_done;
    assign tx_next     = tx_empty_q ? IDLE_BYTE : tx_buf;
    assign rx_byte     = {rx_shift[6:0], mosi_s};

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sync_fill <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_s;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state    <= IDLE;
            armed    <= 1'b0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            miso_q   <= 1'b0;
        end else begin
            if (sync_fill[SYNC_STAGES-1] && cs_s) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (frame_start) begin
                        state    <= SHIFT;
                        armed    <= 1'b0;
                        bit_cnt  <= 3'd0;
                        tx_shift <= tx_next;
                        miso_q   <= tx_next[7];
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state    <= IDLE;
                        bit_cnt  <= 3'd0;
                        rx_shift <= 8'h00;
                        miso_q   <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_byte;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt  <= 3'd0;
                            tx_shift <= tx_next;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end else if (sck_fall) begin
                        miso_q <= tx_shift[7];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reload that finds the buffer empty uses IDLE_BYTE; a same-cycle load then fills the buffer
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            tx_empty_q <= 1'b1;
            tx_buf     <= 8'h00;
        end else if (reload && !tx_empty_q) begin
            tx_empty_q <= 1'b1;
        end else if (bus.tx_load && tx_empty_q) begin
            tx_buf     <= bus.tx_data_bus;
            tx_empty_q <= 1'b0;
        end
    end

    assign bus.miso     = miso_q;
    assign bus.miso_oe  = (state == SHIFT);
    assign bus.tx_empty = tx_empty_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty, push, pop;
    logic        overrun_q;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop        = bus.rx_ack & ~fifo_empty;
    assign push       = byte_done & (~fifo_full | bus.rx_ack);

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem[i] <= 8'h00;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                rx_mem[wr_ptr[PW-1:0]] <= rx_byte;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (byte_done && fifo_full && !bus.rx_ack) begin
                overrun_q <= 1'b1;
            end else if (bus.rx_ack) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data  = rx_mem[rd_ptr[PW-1:0]];
    assign bus.rx_valid = ~fifo_empty;
    assign bus.overrun  = overrun_q;
`else
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       overrun_q;

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (byte_done) begin
            if (!rx_valid_q || bus.rx_ack) begin
                rx_data_q  <= rx_byte;
                rx_valid_q <= 1'b1;
                if (bus.rx_ack) begin
                    overrun_q <= 1'b0;
                end
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (bus.rx_ack) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.overrun  = overrun_q;
`endif
endmodule
